// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer.
// Owns prog_ctr, steps it once per retired instruction, resolves conditional
// absolute branches via the combinational lookup table with no delay slots,
// runs the start/done handshake and stops when HALT_PC is reached.
module pc_sequencer #(
  parameter int D        = 12,
  parameter int START_PC = 0,
  parameter int HALT_PC  = 511
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         cond,
  input  logic [4:0]   lut_idx,
  output logic [4:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] prog_ctr,
  output logic         done,
  output logic [15:0]  instr_cnt
);

  localparam logic [D-1:0] START_V = D'(START_PC);
  localparam logic [D-1:0] HALT_V  = D'(HALT_PC);
  localparam logic [15:0]  CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [D-1:0] pc_nx;
  logic [D-1:0] pc_adv;
  logic [15:0]  cnt_nx;
  logic [15:0]  cnt_inc;
  logic         done_nx;
  logic         taken;

  // Table address is a straight wire; the target comes back the same cycle.
  assign lut_addr = lut_idx;

  // Candidate next PC for an unstalled RUN cycle: taken branch wins over
  // sequential step; the sequential step wraps naturally at 2^D.
  always_comb begin
    taken  = branch_en & cond;
    pc_adv = taken ? lut_target : prog_ctr + {{(D-1){1'b0}}, 1'b1};
  end

  // Saturating retire count.
  always_comb begin
    cnt_inc = (instr_cnt == CNT_MAX) ? instr_cnt : instr_cnt + 16'd1;
  end

  // State register plus the architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prog_ctr  <= START_V;
      done      <= 1'b0;
      instr_cnt <= 16'd0;
    end else begin
      state     <= state_nx;
      prog_ctr  <= pc_nx;
      done      <= done_nx;
      instr_cnt <= cnt_nx;
    end
  end

  // Next-state and next-register logic; everything holds unless a state
  // explicitly changes it.
  always_comb begin
    state_nx = state;
    pc_nx    = prog_ctr;
    done_nx  = done;
    cnt_nx   = instr_cnt;
    unique case (state)
      IDLE, DONE: begin
        // A restart from DONE looks exactly like a start from IDLE.
        if (start) begin
          state_nx = RUN;
          pc_nx    = START_V;
          done_nx  = 1'b0;
          cnt_nx   = 16'd0;
        end
      end
      RUN: begin
        // start is ignored here; stall freezes PC and count together.
        if (!stall) begin
          pc_nx  = pc_adv;
          cnt_nx = cnt_inc;
          // Halt on arrival only, whether sequential or branched.
          if (pc_adv == HALT_V) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        pc_nx    = START_V;
        done_nx  = 1'b0;
        cnt_nx   = 16'd0;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the custom microprocessor. It owns the `prog_ctr` register and advances it once per instruction. Branches take their absolute targets from the 5-bit-indexed PC lookup table; the sequencer drives the table address and receives the target back in the same cycle. It runs a start/done handshake with the top level and detects the halt address. It also counts retired instructions for the testbench.

## Interface
- `D`, 12, program-counter width; must match the lookup-table target width
- `START_PC`, 0, `prog_ctr` value loaded on start and on reset
- `HALT_PC`, 511, address whose arrival ends the program
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level sampled each cycle; begins a run from IDLE or DONE
- `stall`  in  1  hold the PC this cycle
- `branch_en`  in  1  current instruction is a conditional absolute branch
- `cond`  in  1  branch condition flag from the ALU/flags
- `lut_idx`  in  5  branch-target index field of the current instruction
- `lut_addr`  out  5  address to the lookup table (combinational copy of `lut_idx`)
- `lut_target`  in  D  target returned by the lookup table (combinational, same cycle)
- `prog_ctr`  out  D  current instruction address (registered)
- `done`  out  1  program finished (registered, sticky until next start)
- `instr_cnt`  out  16  instructions retired in the current run (registered, saturating)

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `prog_ctr`=START_PC, `done`=0, `instr_cnt`=0.
- **IDLE:**
  - `start`=1 -> RUN next cycle; `prog_ctr`←START_PC, `instr_cnt`←0, `done`←0.
  - Otherwise all registers hold.
- **RUN:** each cycle the next PC is computed with this priority:
  1. `stall`=1 -> hold `prog_ctr` and `instr_cnt`.
  2. `branch_en`=1 and `cond`=1 -> next = `lut_target`.
  3. Otherwise -> next = `prog_ctr`+1, modulo 2^D (all-ones wraps to 0; no error flag).
- On every non-stalled RUN cycle `instr_cnt` increments. It saturates at 0xFFFF.
- Halt rule:
  - If the next PC equals HALT_PC, go to DONE. The same edge loads `prog_ctr`←HALT_PC and `done`←1.
  - This applies whether HALT_PC is reached sequentially or by a branch.
  - A branch that jumps past HALT_PC does not halt.
- `start` is ignored while in RUN.
- Unmapped lookup indices return 0, so a branch jumps to address 0. This is legal and not flagged.
- **DONE:**
  - `prog_ctr`, `done`=1 and `instr_cnt` hold. `stall`, `branch_en` and `cond` are ignored.
  - `start`=1 -> restart exactly as from IDLE: the same edge clears `done` and loads START_PC.
- `lut_addr` follows `lut_idx` combinationally in every state.
- Asserting `reset_n` mid-run immediately forces the reset values and IDLE; no partial update survives.

## Timing
- The lookup table is combinational. The branch target is sampled on the same edge that the branch instruction is presented; there are zero branch delay slots.
- Start latency: `start` sampled high at edge N -> state RUN and `prog_ctr`=START_PC after edge N. The first advance happens at edge N+1.
- Halt latency: `done` rises at the same edge at which `prog_ctr` becomes HALT_PC. There are no extra cycles.
- `stall`, `branch_en`, `cond`, `lut_idx` and `start` are sampled only at rising edges and need no stability beyond setup and hold.
- Reset is asserted asynchronously. Deassertion is assumed synchronized externally; the first edge after deassertion may sample `start`.

## Test plan
- **Reset:** hold `reset_n`=0 while toggling `start` -> `prog_ctr`=0, `done`=0, `instr_cnt`=0; release, no `start` for 5 cycles -> all values unchanged.
- **Straight line:** pulse `start`, keep `branch_en`=0 -> `prog_ctr` steps 0,1,2,…,511; `done`=1 on the edge `prog_ctr`=511; `instr_cnt`=511; afterwards everything holds.
- **Branch:**
  - At `prog_ctr`=5 with `branch_en`=1, `cond`=1, `lut_idx`=10 (target 15) -> next `prog_ctr`=15 and `lut_addr`=10.
  - Same at PC 5 with `cond`=0 -> next `prog_ctr`=6.
- **Branch to halt:** at `prog_ctr`=37, `branch_en`=1, `cond`=1, `lut_idx`=20 (target 511) -> `prog_ctr`=511 and `done`=1 on the next edge.
- **Stall:**
  - Assert `stall` for 3 cycles at `prog_ctr`=22 -> PC stays 22 and `instr_cnt` frozen.
  - `stall`=1 together with a taken branch -> PC still holds; the branch resolves when `stall` drops.
- **Reset and restart:**
  - Drop `reset_n` asynchronously at `prog_ctr`=40 -> immediately 0 and IDLE.
  - Separately, from DONE assert `start` -> `done`=0, `prog_ctr`=0, `instr_cnt`=0 on the same edge; the run resumes normally.
